imm_encoder: RTL and testbench

Pipelined immediate packer for the RISC-V single-cycle CPU toolchain/test path. It takes a base instruction word, an immediate-format select and a signed immediate value, then range-checks the value. It packs the value into instruction bits [31:7] using exactly the field layout and word-offset scaling that the immediate generator decodes. It is used by the instruction-memory loader and by self-checking benches to build instructions, with a valid/ready handshake on both sides.

---
 rtl/riscv_pkg.sv | 47 ++++
 rtl/imm_pack_fmt.sv | 57 +++++
 rtl/imm_encoder.sv | 112 +++++++++++
 tb/tb_imm_encoder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V immediate definitions: ImmSel codes, 25-bit field masks over instr[31:7],
// and the range check applied to the unshifted immediate.
package riscv_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_IU   = 3'b001,
    IMM_SH   = 3'b010,
    IMM_S    = 3'b011,
    IMM_B    = 3'b100,
    IMM_U    = 3'b101,
    IMM_J    = 3'b110,
    IMM_JALR = 3'b111
  } imm_sel_e;

  localparam logic [24:0] MASK_I  = 25'h1FFE000;
  localparam logic [24:0] MASK_SH = 25'h003E000;
  localparam logic [24:0] MASK_S  = 25'h1FC001F;
  localparam logic [24:0] MASK_B  = 25'h1FC001F;
  localparam logic [24:0] MASK_U  = 25'h1FFFFE0;
  localparam logic [24:0] MASK_J  = 25'h1FFFFE0;

  // Word-offset formats carry imm_val in words; the packed field holds bytes.
  function automatic logic is_word_offset(input logic [2:0] sel);
    return (sel == IMM_B) || (sel == IMM_J) || (sel == IMM_JALR);
  endfunction

  // Checked on the full signed value before scaling, so a shift can never wrap into range.
  function automatic logic imm_in_range(input logic [2:0] sel, input logic [31:0] imm);
    logic signed [31:0] v;
    logic               ok;
    v  = $signed(imm);
    ok = 1'b0;
    case (sel)
      IMM_I, IMM_S: ok = (v >= -32'sd2048)   && (v <= 32'sd2047);
      IMM_IU:       ok = (v >= 32'sd0)       && (v <= 32'sd4095);
      IMM_SH:       ok = (v >= -32'sd16)     && (v <= 32'sd15);
      IMM_B:        ok = (v >= -32'sd1024)   && (v <= 32'sd1023);
      IMM_U:        ok = (imm[11:0] == 12'h000);
      IMM_J:        ok = (v >= -32'sd262144) && (v <= 32'sd262143);
      IMM_JALR:     ok = (v >= -32'sd512)    && (v <= 32'sd511);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/imm_pack_fmt.sv
// Combinational field packer: scatters the (byte-scaled) immediate into instr[31:7]
// layout for the selected format and reports which field bits it owns.
module imm_pack_fmt
  import riscv_pkg::*;
(
  input  logic [2:0]  imm_sel_i,
  input  logic [31:0] imm_val_i,
  output logic [24:0] pack_o,
  output logic [24:0] mask_o
);

  logic [31:0] b;

  always_comb begin
    b      = is_word_offset(imm_sel_i) ? (imm_val_i << 2) : imm_val_i;
    pack_o = '0;
    mask_o = '0;
    case (imm_sel_i)
      IMM_I, IMM_IU, IMM_JALR: begin
        pack_o[24:13] = b[11:0];
        mask_o        = MASK_I;
      end
      IMM_SH: begin
        pack_o[17:13] = b[4:0];
        mask_o        = MASK_SH;
      end
      IMM_S: begin
        pack_o[24:18] = b[11:5];
        pack_o[4:0]   = b[4:0];
        mask_o        = MASK_S;
      end
      IMM_B: begin
        pack_o[24]    = b[12];
        pack_o[0]     = b[11];
        pack_o[23:18] = b[10:5];
        pack_o[4:1]   = b[4:1];
        mask_o        = MASK_B;
      end
      IMM_U: begin
        pack_o[24:5]  = b[31:12];
        mask_o        = MASK_U;
      end
      IMM_J: begin
        pack_o[24]    = b[20];
        pack_o[12:5]  = b[19:12];
        pack_o[13]    = b[11];
        pack_o[23:14] = b[10:1];
        mask_o        = MASK_J;
      end
      default: begin
        pack_o = '0;
        mask_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate packer with valid/ready on both sides (check stage, pack stage).
// Optional IMM_ENCODER_ERRCNT_EN adds a saturating err_cnt of drained error results.
module imm_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  ImmSel,
  input  logic [31:0] imm_val,
  input  logic [31:0] base_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
`ifdef IMM_ENCODER_ERRCNT_EN
  output logic [7:0]  err_cnt,
`endif
  output logic        err
);

  logic        s1_valid_q, s1_valid_d;
  logic [2:0]  s1_sel_q, s1_sel_d;
  logic [31:0] s1_imm_q, s1_imm_d;
  logic [31:0] s1_base_q, s1_base_d;
  logic        s1_ok_q, s1_ok_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_instr_q, s2_instr_d;
  logic        s2_err_q, s2_err_d;

  logic        s2_adv;
  logic        accept;
  logic [24:0] pack;
  logic [24:0] mask;

  imm_pack_fmt u_pack (
    .imm_sel_i (s1_sel_q),
    .imm_val_i (s1_imm_q),
    .pack_o    (pack),
    .mask_o    (mask)
  );

  // Stage 1 only moves on when stage 2 does; an empty stage 1 may always fill.
  always_comb begin
    s2_adv     = !s2_valid_q | out_ready;
    in_ready   = !s1_valid_q | s2_adv;
    accept     = in_valid & in_ready;

    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s1_sel_d   = accept ? ImmSel : s1_sel_q;
    s1_imm_d   = accept ? imm_val : s1_imm_q;
    s1_base_d  = accept ? base_instr : s1_base_q;
    s1_ok_d    = accept ? imm_in_range(ImmSel, imm_val) : s1_ok_q;

    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    if (s2_adv && s1_valid_q) begin
      s2_err_d   = !s1_ok_q;
      s2_instr_d = s1_ok_q ? {(s1_base_q[31:7] & ~mask) | (pack & mask), s1_base_q[6:0]}
                           : s1_base_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sel_q   <= '0;
      s1_imm_q   <= '0;
      s1_base_q  <= '0;
      s1_ok_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sel_q   <= s1_sel_d;
      s1_imm_q   <= s1_imm_d;
      s1_base_q  <= s1_base_d;
      s1_ok_q    <= s1_ok_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign instr     = s2_instr_q;
  assign err       = s2_err_q;

`ifdef IMM_ENCODER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s2_valid_q && out_ready && s2_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed scoreboard bench for imm_encoder; expected words come from a field-level model.
module tb_imm_encoder;
  import riscv_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ImmSel;
  logic [31:0] imm_val;
  logic [31:0] base_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;
`ifdef IMM_ENCODER_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  exp_t        sbQueue[$];
  int          assertCount = 0;
  int          failCount   = 0;
  int          acceptCount = 0;
  int          drainCount  = 0;
  logic [31:0] lastInstr;
  logic        lastErr;

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ImmSel     (ImmSel),
    .imm_val    (imm_val),
    .base_instr (base_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr      (instr),
`ifdef IMM_ENCODER_ERRCNT_EN
    .err_cnt    (err_cnt),
`endif
    .err        (err)
  );

  // Reference: overwrite the instruction bits each format owns, written in instr[] terms.
  function automatic exp_t modelEncode(input logic [2:0] sel, input logic [31:0] imm,
                                       input logic [31:0] base);
    exp_t        e;
    longint      v;
    logic [31:0] b;
    logic        ok;
    v  = longint'($signed(imm));
    b  = (sel == 3'd4 || sel == 3'd6 || sel == 3'd7) ? (imm << 2) : imm;
    ok = 1'b0;
    case (sel)
      3'd0, 3'd3: ok = (v >= -2048) && (v <= 2047);
      3'd1:       ok = (v >= 0) && (v <= 4095);
      3'd2:       ok = (v >= -16) && (v <= 15);
      3'd4:       ok = (v >= -1024) && (v <= 1023);
      3'd5:       ok = (imm[11:0] == 12'h000);
      3'd6:       ok = (v >= -262144) && (v <= 262143);
      default:    ok = (v >= -512) && (v <= 511);
    endcase
    e.instr = base;
    e.err   = !ok;
    if (ok) begin
      case (sel)
        3'd0, 3'd1, 3'd7: e.instr[31:20] = b[11:0];
        3'd2: e.instr[24:20] = b[4:0];
        3'd3: begin
          e.instr[31:25] = b[11:5];
          e.instr[11:7]  = b[4:0];
        end
        3'd4: begin
          e.instr[31]    = b[12];
          e.instr[7]     = b[11];
          e.instr[30:25] = b[10:5];
          e.instr[11:8]  = b[4:1];
        end
        3'd5: e.instr[31:12] = b[31:12];
        default: begin
          e.instr[31]    = b[20];
          e.instr[30:21] = b[10:1];
          e.instr[20]    = b[11];
          e.instr[19:12] = b[19:12];
        end
      endcase
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] sel, input logic [31:0] imm,
                               input logic [31:0] base, input logic vld);
    ImmSel     = sel;
    imm_val    = imm;
    base_instr = base;
    in_valid   = vld;
  endtask

  // One clock: drain/compare, then record accepts, sampled 1ns after the falling edge.
  task automatic cycle();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (sbQueue.size() == 0) begin
        checkOutput("spuriousOut", {31'b0, out_valid}, 32'd0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("instr", instr, e.instr);
        checkOutput("err", {31'b0, err}, {31'b0, e.err});
        lastInstr = instr;
        lastErr   = err;
        drainCount++;
      end
    end
    if (in_valid && in_ready) begin
      sbQueue.push_back(modelEncode(ImmSel, imm_val, base_instr));
      acceptCount++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic runOne(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
    lastInstr = 32'hDEADBEEF;
    lastErr   = 1'bx;
    out_ready = 1'b1;
    applyStimulus(sel, imm, base, 1'b1);
    cycle();
    applyStimulus(sel, imm, base, 1'b0);
    for (int i = 0; i < 8 && sbQueue.size() != 0; i++) cycle();
    checkOutput("sbDrained", 32'(sbQueue.size()), 32'd0);
  endtask

  logic [2:0]  tSel[10]  = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
  int          tImm[10]  = '{2047, 2048, -1, 4095, -16, 16, -2048, -1025, 262143, -512};
  logic        tErr[10]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int reqIdx;
    int prevAcc;
    rst = 1'b1;
    out_ready = 1'b1;
    applyStimulus(3'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rstOutValid", {31'b0, out_valid}, 32'd0);
    checkOutput("rstInstr", instr, 32'd0);
    checkOutput("rstErr", {31'b0, err}, 32'd0);
`ifdef IMM_ENCODER_ERRCNT_EN
    checkOutput("rstErrCnt", {24'b0, err_cnt}, 32'd0);
`endif
    rst = 1'b0;
    checkOutput("rstInReady", {31'b0, in_ready}, 32'd1);

    // I-type -1 with explicit 2-cycle latency
    $display("[TB] I-type latency");
    applyStimulus(IMM_I, 32'hFFFFFFFF, 32'h00000013, 1'b1);
    cycle();
    applyStimulus(IMM_I, 32'hFFFFFFFF, 32'h00000013, 1'b0);
    #1 checkOutput("lat1", {31'b0, out_valid}, 32'd0);
    cycle();
    #1 checkOutput("lat2", {31'b0, out_valid}, 32'd1);
    cycle();
    checkOutput("iConst", lastInstr, 32'hFFF00013);
    checkOutput("iErr", {31'b0, lastErr}, 32'd0);

    $display("[TB] directed formats");
    runOne(IMM_B, 32'd3, 32'h00000063);
    checkOutput("bConst", lastInstr, 32'h00000663);
    runOne(IMM_U, 32'h12345000, 32'h00000037);
    checkOutput("uConst", lastInstr, 32'h12345037);
    runOne(IMM_U, 32'h12345001, 32'h00000037);
    checkOutput("uErrInstr", lastInstr, 32'h00000037);
    checkOutput("uErr", {31'b0, lastErr}, 32'd1);
    runOne(IMM_JALR, 32'd511, 32'h00000067);
    checkOutput("jalrConst", lastInstr, 32'h7FC00067);
    runOne(IMM_JALR, 32'd512, 32'h00000067);
    checkOutput("jalrErr", {31'b0, lastErr}, 32'd1);
    runOne(IMM_J, 32'hFFFC0000, 32'h0000006F);
    checkOutput("jBit31", {31'b0, lastInstr[31]}, 32'd1);
    checkOutput("jConst", lastInstr, 32'h8000006F);

    $display("[TB] range boundaries over a busy base word");
    for (int i = 0; i < 10; i++) begin
      runOne(tSel[i], 32'(tImm[i]), 32'h5A5A5A5A ^ 32'(i));
      checkOutput("boundErr", {31'b0, lastErr}, {31'b0, tErr[i]});
    end

    $display("[TB] streaming throughput");
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(3'(k), 32'(k * 3 - 7), 32'hA5000013 + 32'(k << 7), 1'b1);
      #1 checkOutput("tputReady", {31'b0, in_ready}, 32'd1);
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8 && sbQueue.size() != 0; i++) cycle();
    checkOutput("tputDrained", 32'(sbQueue.size()), 32'd0);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    acceptCount = 0;
    drainCount = 0;
    reqIdx = 0;
    for (int n = 0; n < 4; n++) begin
      applyStimulus(IMM_I, 32'(reqIdx * 100 + 1), 32'h00000013 | 32'(reqIdx << 7), 1'b1);
      prevAcc = acceptCount;
      cycle();
      if (acceptCount != prevAcc) reqIdx++;
    end
    checkOutput("bpAccepted", 32'(acceptCount), 32'd2);
    applyStimulus(IMM_I, 32'(reqIdx * 100 + 1), 32'h00000013 | 32'(reqIdx << 7), 1'b1);
    #1 checkOutput("bpInReady", {31'b0, in_ready}, 32'd0);
    checkOutput("bpHoldValid", {31'b0, out_valid}, 32'd1);
    if (sbQueue.size() != 0) checkOutput("bpHoldInstr", instr, sbQueue[0].instr);
    out_ready = 1'b1;
    for (int n = 0; n < 20 && drainCount < 4; n++) begin
      if (reqIdx < 4)
        applyStimulus(IMM_I, 32'(reqIdx * 100 + 1), 32'h00000013 | 32'(reqIdx << 7), 1'b1);
      else
        in_valid = 1'b0;
      prevAcc = acceptCount;
      cycle();
      if (acceptCount != prevAcc) reqIdx++;
    end
    in_valid = 1'b0;
    checkOutput("bpDrainCount", 32'(drainCount), 32'd4);
    checkOutput("bpQueueEmpty", 32'(sbQueue.size()), 32'd0);

    $display("[TB] reset with entries in flight");
    out_ready = 1'b0;
    applyStimulus(IMM_S, 32'd20, 32'h00002023, 1'b1);
    cycle();
    applyStimulus(IMM_S, 32'd24, 32'h00002023, 1'b1);
    cycle();
    in_valid = 1'b0;
    #1 checkOutput("midPre", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midOutValid", {31'b0, out_valid}, 32'd0);
    checkOutput("midInstr", instr, 32'd0);
    @(negedge clk);
    sbQueue.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    #1 checkOutput("midNoGhost", {31'b0, out_valid}, 32'd0);

`ifdef IMM_ENCODER_ERRCNT_EN
    $display("[TB] error counter");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sbQueue.delete();
    out_ready = 1'b1;
    applyStimulus(IMM_JALR, 32'd512, 32'h00000067, 1'b1);
    repeat (10) cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 8 && sbQueue.size() != 0; i++) cycle();
    checkOutput("errCnt10", {24'b0, err_cnt}, 32'd10);
    in_valid = 1'b1;
    repeat (290) cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 8 && sbQueue.size() != 0; i++) cycle();
    checkOutput("errCntSat", {24'b0, err_cnt}, 32'd255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
